alu_flags_cond: RTL and testbench

- Sits directly downstream of the 16-bit ALU.
- Latches the ALU's carry, zero and less-than flags into a flags register.
- Generates the ALU's carry-in from a selectable source, including the latched carry, so multi-word add and subtract can be chained.
- Evaluates microcode jump conditions against the flags and produces a registered jump-take pulse for the PC-load logic.

---
 rtl/alu_flags_cond_pkg.sv | 26 ++
 rtl/alu_flags_cond_cond_match.sv | 25 ++
 rtl/alu_flags_cond.sv | 112 +++++++++++
 tb/tb_alu_flags_cond.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/alu_flags_cond_pkg.sv
// rtl/alu_flags_cond_pkg.sv - shared encodings for the ALU flags / condition block
//
// Package alu_defs:
//   cin_sel encodings  : CIN_ZERO, CIN_ONE, CIN_CARRY, CIN_NCARRY
//   cond bit indices   : COND_Z, COND_LT, COND_GT
//   flags bit indices  : FLAG_C, FLAG_Z, FLAG_LT
package alu_defs;

    typedef enum logic [1:0] {
        CIN_ZERO   = 2'b00,
        CIN_ONE    = 2'b01,
        CIN_CARRY  = 2'b10,
        CIN_NCARRY = 2'b11
    } cin_sel_e;

    localparam int COND_Z  = 0;
    localparam int COND_LT = 1;
    localparam int COND_GT = 2;

    localparam int FLAG_C  = 0;
    localparam int FLAG_Z  = 1;
    localparam int FLAG_LT = 2;

    localparam int FLAGS_W = 3;

endpackage

// File: rtl/alu_flags_cond_cond_match.sv
// rtl/alu_flags_cond_cond_match.sv - combinational jump-condition match
//
// Ports:
//   lt   in   less-than flag of the evaluated flag set
//   z    in   zero flag of the evaluated flag set
//   cond in   condition mask (bit COND_Z / COND_LT / COND_GT)
//   hit  out  1 when any enabled condition is true
module cond_match
    import alu_defs::*;
#(
    parameter int COND_W = 3
) (
    input  logic              lt,
    input  logic              z,
    input  logic [COND_W-1:0] cond,
    output logic              hit
);

    logic gt;

    // Greater-than is "neither equal nor less".
    assign gt  = ~z & ~lt;
    assign hit = (cond[COND_Z] & z) | (cond[COND_LT] & lt) | (cond[COND_GT] & gt);

endmodule

// File: rtl/alu_flags_cond.sv
// rtl/alu_flags_cond.sv - ALU flags register, carry-in select and jump condition pulse
//
// Ports:
//   clk, reset_bar          clock, asynchronous active-low reset
//   alu_C, alu_Z, alu_LT    flags from the ALU
//   flags_load              capture ALU flags at this edge
//   cin_sel                 carry-in source (alu_defs::cin_sel_e)
//   cond, cond_eval         jump-condition mask and evaluate strobe
//   C_in                    combinational carry-in to the ALU
//   flags, flags_valid      latched {LT, Z, C}, loaded-since-reset
//   take_jump, eval_err     registered one-cycle result pulses
module alu_flags_cond
    import alu_defs::*;
#(
    parameter int   COND_W      = 3,
    parameter logic CARRY_RESET = 1'b0
) (
    input  logic              clk,
    input  logic              reset_bar,
    input  logic              alu_C,
    input  logic              alu_Z,
    input  logic              alu_LT,
    input  logic              flags_load,
    input  logic [1:0]        cin_sel,
    input  logic [COND_W-1:0] cond,
    input  logic              cond_eval,
    output logic              C_in,
    output logic [2:0]        flags,
    output logic              flags_valid,
    output logic              take_jump,
    output logic              eval_err
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } state_e;

    state_e state;

    logic [2:0] alu_flags;
    logic [2:0] eval_flags;
    logic       eval_valid;
    logic       hit;

    assign alu_flags = {alu_LT, alu_Z, alu_C};

    // A same-cycle load is bypassed into the evaluation so the condition
    // sees the flags of the instruction completing now, not stale ones.
    assign eval_flags = flags_load ? alu_flags : flags;
    assign eval_valid = flags_valid | flags_load;

    cond_match #(
        .COND_W(COND_W)
    ) u_cond_match (
        .lt  (eval_flags[FLAG_LT]),
        .z   (eval_flags[FLAG_Z]),
        .cond(cond),
        .hit (hit)
    );

    // Carry-in uses only the latched carry, so a load this cycle is seen
    // by the ALU on the next word (ADC/SBC chaining).
    always_comb begin
        C_in = 1'b0;
        case (cin_sel_e'(cin_sel))
            CIN_ZERO:   C_in = 1'b0;
            CIN_ONE:    C_in = 1'b1;
            CIN_CARRY:  C_in = flags[FLAG_C];
            CIN_NCARRY: C_in = ~flags[FLAG_C];
            default:    C_in = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            flags       <= {2'b00, CARRY_RESET};
            flags_valid <= 1'b0;
        end else if (flags_load) begin
            flags       <= alu_flags;
            flags_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            state     <= ST_IDLE;
            take_jump <= 1'b0;
            eval_err  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_PULSE: begin
                    if (cond_eval) begin
                        state     <= ST_PULSE;
                        take_jump <= eval_valid & hit;
                        eval_err  <= ~eval_valid;
                    end else begin
                        state     <= ST_IDLE;
                        take_jump <= 1'b0;
                        eval_err  <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    take_jump <= 1'b0;
                    eval_err  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_flags_cond.sv
// tb/tb_alu_flags_cond.sv - directed self-checking bench for alu_flags_cond
module tb_alu_flags_cond;

    logic       clk;
    logic       reset_bar;
    logic       alu_C;
    logic       alu_Z;
    logic       alu_LT;
    logic       flags_load;
    logic [1:0] cin_sel;
    logic [2:0] cond;
    logic       cond_eval;
    logic       C_in;
    logic [2:0] flags;
    logic       flags_valid;
    logic       take_jump;
    logic       eval_err;

    int vectors;
    int miscompares;

    alu_flags_cond #(
        .COND_W(3),
        .CARRY_RESET(1'b0)
    ) dut (
        .clk        (clk),
        .reset_bar  (reset_bar),
        .alu_C      (alu_C),
        .alu_Z      (alu_Z),
        .alu_LT     (alu_LT),
        .flags_load (flags_load),
        .cin_sel    (cin_sel),
        .cond       (cond),
        .cond_eval  (cond_eval),
        .C_in       (C_in),
        .flags      (flags),
        .flags_valid(flags_valid),
        .take_jump  (take_jump),
        .eval_err   (eval_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_bar = 1'b0; alu_C = 0; alu_Z = 0; alu_LT = 0;
        flags_load = 0; cin_sel = 2'b10; cond = 3'b000; cond_eval = 0;
        step(); step();
        vectors++; if (C_in !== 1'b0) begin miscompares++; $display("FAIL rst_cin got %b want 0", C_in); end
        vectors++; if (flags !== 3'b000) begin miscompares++; $display("FAIL rst_flags got %b want 000", flags); end
        vectors++; if (flags_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", flags_valid); end
        vectors++; if (take_jump !== 1'b0 || eval_err !== 1'b0) begin miscompares++; $display("FAIL rst_pulses got tj=%b err=%b want 0 0", take_jump, eval_err); end
        reset_bar = 1'b1;
        cond_eval = 1; cond = 3'b111;
        step();
        cond_eval = 0;
        vectors++; if (take_jump !== 1'b0 || eval_err !== 1'b1) begin miscompares++; $display("FAIL invalid_eval got tj=%b err=%b want 0 1", take_jump, eval_err); end
        step();
        vectors++; if (eval_err !== 1'b0) begin miscompares++; $display("FAIL err_one_cycle got %b want 0", eval_err); end
    endtask

    task automatic test_load_eval();
        flags_load = 1; alu_LT = 0; alu_Z = 1; alu_C = 1;
        step();
        flags_load = 0;
        vectors++; if (flags !== 3'b011 || flags_valid !== 1'b1) begin miscompares++; $display("FAIL load_flags got %b/%b want 011/1", flags, flags_valid); end
        cond_eval = 1; cond = 3'b001;
        step();
        cond_eval = 0;
        vectors++; if (take_jump !== 1'b1 || eval_err !== 1'b0) begin miscompares++; $display("FAIL eval_z got tj=%b err=%b want 1 0", take_jump, eval_err); end
        step();
        vectors++; if (take_jump !== 1'b0) begin miscompares++; $display("FAIL tj_one_cycle got %b want 0", take_jump); end
        cond_eval = 1; cond = 3'b110;
        step();
        cond_eval = 0;
        vectors++; if (take_jump !== 1'b0 || eval_err !== 1'b0) begin miscompares++; $display("FAIL eval_ltgt got tj=%b err=%b want 0 0", take_jump, eval_err); end
        cond_eval = 1; cond = 3'b000;
        step();
        cond_eval = 0;
        vectors++; if (take_jump !== 1'b0) begin miscompares++; $display("FAIL eval_none got %b want 0", take_jump); end
    endtask

    task automatic test_bypass();
        flags_load = 1; alu_LT = 1; alu_Z = 0; alu_C = 0;
        step();
        vectors++; if (flags !== 3'b100) begin miscompares++; $display("FAIL bypass_pre got %b want 100", flags); end
        alu_LT = 0; alu_Z = 0; alu_C = 0;
        cond_eval = 1; cond = 3'b100;
        step();
        flags_load = 0; cond_eval = 0;
        vectors++; if (take_jump !== 1'b1) begin miscompares++; $display("FAIL bypass_gt got %b want 1", take_jump); end
        vectors++; if (flags !== 3'b000) begin miscompares++; $display("FAIL bypass_flags got %b want 000", flags); end
    endtask

    task automatic test_carry();
        // low word 0xFFFF + 0x0001 = 0x0000: C=1, Z=1, LT=0
        cin_sel = 2'b10;
        flags_load = 1; alu_C = 1; alu_Z = 1; alu_LT = 0;
        #1;
        vectors++; if (C_in !== 1'b0) begin miscompares++; $display("FAIL cin_old_carry got %b want 0", C_in); end
        step();
        flags_load = 0;
        vectors++; if (C_in !== 1'b1) begin miscompares++; $display("FAIL cin_carry got %b want 1", C_in); end
        cin_sel = 2'b11; #1;
        vectors++; if (C_in !== 1'b0) begin miscompares++; $display("FAIL cin_ncarry got %b want 0", C_in); end
        cin_sel = 2'b00; #1;
        vectors++; if (C_in !== 1'b0) begin miscompares++; $display("FAIL cin_zero got %b want 0", C_in); end
        cin_sel = 2'b01; #1;
        vectors++; if (C_in !== 1'b1) begin miscompares++; $display("FAIL cin_one got %b want 1", C_in); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] zpat;
        logic [2:0] want;
        zpat = 3'b101;
        want = 3'b101;
        cond = 3'b001; cond_eval = 1; flags_load = 1; alu_C = 0; alu_LT = 0;
        for (int i = 0; i < 3; i++) begin
            alu_Z = zpat[i];
            step();
            vectors++;
            if (take_jump !== want[i] || eval_err !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_%0d got tj=%b err=%b want %b 0", i, take_jump, eval_err, want[i]);
            end
        end
        cond_eval = 0; flags_load = 0;
        step();
        vectors++; if (take_jump !== 1'b0) begin miscompares++; $display("FAIL b2b_end got %b want 0", take_jump); end
    endtask

    task automatic test_mid_reset();
        cin_sel = 2'b10;
        flags_load = 1; alu_C = 1; alu_Z = 1; alu_LT = 0;
        cond_eval = 1; cond = 3'b001;
        step();
        flags_load = 0; cond_eval = 0;
        vectors++; if (take_jump !== 1'b1) begin miscompares++; $display("FAIL mr_pre got %b want 1", take_jump); end
        #2 reset_bar = 1'b0;
        #1;
        vectors++; if (take_jump !== 1'b0) begin miscompares++; $display("FAIL mr_tj got %b want 0", take_jump); end
        vectors++; if (flags !== 3'b000 || flags_valid !== 1'b0) begin miscompares++; $display("FAIL mr_flags got %b/%b want 000/0", flags, flags_valid); end
        vectors++; if (C_in !== 1'b0) begin miscompares++; $display("FAIL mr_cin got %b want 0", C_in); end
        step();
        reset_bar = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (take_jump !== 1'b0 || eval_err !== 1'b0) begin
                miscompares++;
                $display("FAIL mr_post_%0d got tj=%b err=%b want 0 0", i, take_jump, eval_err);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_load_eval();
        test_bypass();
        test_carry();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
